// File: rtl/lsu.sv
// lsu: load/store unit sitting after the ALU. Turns an effective address,
// store data and access size into one single-outstanding req/gnt/rvalid
// data-memory transaction, then returns sign/zero-extended load data.
//
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned or
// reserved-size accesses with an lsu_err_o pulse and no bus traffic.
// Without it, the low address bits are ignored, the access proceeds
// aligned-down, size 2'b11 behaves as a word access, and lsu_err_o stays 0.
//
// Ports
//   clk, rst_n       core clock, async active-low reset
//   lsu_req_i        start an access (sampled only while idle)
//   lsu_we_i         1 = store, 0 = load
//   lsu_size_i       00 byte, 01 half, 10 word, 11 reserved
//   lsu_unsigned_i   zero-extend (1) or sign-extend (0) load data
//   lsu_addr_i       effective address
//   lsu_wdata_i      store data
//   lsu_busy_o       transaction in flight (stall the core)
//   lsu_done_o       one-cycle completion pulse
//   lsu_rdata_o      extended load data, updated with lsu_done_o
//   lsu_err_o        misaligned/reserved pulse, coincident with lsu_done_o
//   data_*           memory port: req/gnt handshake, rvalid response
module lsu #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    lsu_req_i,
   input  logic                    lsu_we_i,
   input  logic [1:0]              lsu_size_i,
   input  logic                    lsu_unsigned_i,
   input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
   input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
   output logic                    lsu_busy_o,
   output logic                    lsu_done_o,
   output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
   output logic                    lsu_err_o,
   output logic                    data_req_o,
   input  logic                    data_gnt_i,
   output logic [ADDR_WIDTH-1:0]   data_addr_o,
   output logic                    data_we_o,
   output logic [DATA_WIDTH/8-1:0] data_be_o,
   output logic [DATA_WIDTH-1:0]   data_wdata_o,
   input  logic                    data_rvalid_i,
   input  logic [DATA_WIDTH-1:0]   data_rdata_i
);
   localparam int NUM_LANES = DATA_WIDTH / 8;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t                      st;
   logic                        we_q, uns_q, done_q, err_q;
   logic [1:0]                  size_q;
   logic [ADDR_WIDTH-1:0]       addr_q;
   logic [NUM_LANES-1:0]        be_q;
   logic [NUM_LANES-1:0][7:0]   wd_q;
   logic [DATA_WIDTH-1:0]       rdata_q;

   logic [1:0]                  size_eff;
   logic                        trap;
   logic [NUM_LANES-1:0]        be_n;
   logic [NUM_LANES-1:0][7:0]   wd_rep;
   logic [7:0]                  ld_b;
   logic [15:0]                 ld_h;
   logic [DATA_WIDTH-1:0]       ld_ext;

   // Reserved size collapses to word; with the trap enabled it never gets
   // latched anyway because it is rejected in IDLE.
   assign size_eff = (lsu_size_i == 2'b11) ? 2'b10 : lsu_size_i;

`ifdef MISALIGN_TRAP_EN
   assign trap = (lsu_size_i == 2'b11)
              | ((lsu_size_i == 2'b01) & lsu_addr_i[0])
              | ((lsu_size_i == 2'b10) & (|lsu_addr_i[1:0]));
`else
   assign trap = 1'b0;
`endif

   // Per byte lane: enable and replicated store byte, computed from the
   // incoming request so they can be latched once and held through REQ.
   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      always_comb begin
         case (size_eff)
            2'b00:   wd_rep[i] = lsu_wdata_i[7:0];
            2'b01:   wd_rep[i] = lsu_wdata_i[8*(i%2) +: 8];
            default: wd_rep[i] = lsu_wdata_i[8*i +: 8];
         endcase
         case (size_eff)
            2'b00:   be_n[i] = (lsu_addr_i[1:0] == 2'(i));
            2'b01:   be_n[i] = (lsu_addr_i[1] == 1'(i/2));
            default: be_n[i] = 1'b1;
         endcase
      end
   end

   // Load lane extraction uses the latched address (aligned-down for half).
   assign ld_b = data_rdata_i[8*addr_q[1:0] +: 8];
   assign ld_h = data_rdata_i[16*addr_q[1] +: 16];

   always_comb begin
      case (size_q)
         2'b00:   ld_ext = {{(DATA_WIDTH-8){~uns_q & ld_b[7]}}, ld_b};
         2'b01:   ld_ext = {{(DATA_WIDTH-16){~uns_q & ld_h[15]}}, ld_h};
         default: ld_ext = data_rdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         size_q  <= 2'b00;
         addr_q  <= '0;
         be_q    <= '0;
         wd_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         case (st)
            IDLE: if (lsu_req_i) begin
               if (trap) begin
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  we_q   <= lsu_we_i;
                  uns_q  <= lsu_unsigned_i;
                  size_q <= size_eff;
                  addr_q <= lsu_addr_i;
                  be_q   <= be_n;
                  wd_q   <= wd_rep;
                  st     <= REQ;
               end
            end
            REQ: if (data_gnt_i) st <= WAIT;
            WAIT: if (data_rvalid_i) begin
               st      <= IDLE;
               done_q  <= 1'b1;
               rdata_q <= we_q ? '0 : ld_ext;
            end
            default: st <= IDLE;
         endcase
      end
   end

   // Bus fields are only driven while the request is outstanding.
   assign data_req_o   = (st == REQ);
   assign data_addr_o  = data_req_o ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign data_we_o    = data_req_o & we_q;
   assign data_be_o    = data_req_o ? be_q : '0;
   assign data_wdata_o = data_req_o ? wd_q : '0;

   assign lsu_busy_o  = (st != IDLE);
   assign lsu_done_o  = done_q;
   assign lsu_err_o   = err_q;
   assign lsu_rdata_o = rdata_q;
endmodule
